// File: rtl/count_sched.sv
// count_sched: round-robin scheduler sharing one start/stop interval counter among NREQ requesters.
// Sequences the winner through clear, start, run-to-target and stop; reports done, abort or timeout.
module count_sched #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned CW   = 4,
  parameter int unsigned TMO  = 20
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*CW-1:0]   target,
  output logic [NREQ-1:0]      gnt,
  output logic [NREQ-1:0]      done,
  output logic                 err,
  output logic                 busy,
  output logic [CW-1:0]        result,
  output logic                 cnt_rst,
  output logic                 cnt_start,
  output logic                 cnt_stop,
  input  logic [CW-1:0]        count
);
  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned WW = $clog2(TMO);

  typedef enum logic [2:0] {StIdle, StClear, StArm, StRun, StStop} state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   rr_q, rr_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [CW-1:0]   tgt_q, tgt_d;
  logic [WW-1:0]   wd_q, wd_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            err_q, err_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   result_q, result_d;
  logic            cnt_rst_q, cnt_rst_d;
  logic            cnt_start_q, cnt_start_d;
  logic            cnt_stop_q, cnt_stop_d;

  logic [IW-1:0]   pick, cand;
  logic            found;
  logic [CW-1:0]   pick_tgt;

  // First requester at or above the rr pointer, wrapping modulo NREQ.
  always_comb begin
    pick     = '0;
    cand     = '0;
    found    = 1'b0;
    pick_tgt = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      cand = IW'((int'(rr_q) + i) % int'(NREQ));
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick == IW'(i)) pick_tgt = target[i*CW +: CW];
    end
  end

  always_comb begin
    state_d  = state_q;
    rr_d     = rr_q;
    idx_d    = idx_q;
    tgt_d    = tgt_q;
    wd_d     = wd_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    err_d    = 1'b0;
    result_d = result_q;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          idx_d       = pick;
          tgt_d       = pick_tgt;
          gnt_d       = '0;
          gnt_d[pick] = 1'b1;
          state_d     = StClear;
        end
      end
      StClear: begin
        // A zero target completes immediately without ever starting the counter.
        if (tgt_q == '0) begin
          state_d  = StStop;
          result_d = '0;
          done_d   = gnt_q;
        end else begin
          state_d = StArm;
        end
      end
      StArm: begin
        wd_d    = '0;
        state_d = StRun;
      end
      StRun: begin
        if (!(|(req & gnt_q))) begin
          state_d = StStop;
        end else if (wd_q == WW'(TMO - 1)) begin
          state_d = StStop;
          err_d   = 1'b1;
        end else if (count == tgt_q) begin
          state_d  = StStop;
          result_d = count;
          done_d   = gnt_q;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      StStop: begin
        state_d = StIdle;
        gnt_d   = '0;
        rr_d    = (idx_q == IW'(NREQ - 1)) ? '0 : idx_q + 1'b1;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
    busy_d      = (state_d != StIdle);
    cnt_rst_d   = (state_d == StIdle) || (state_d == StClear);
    cnt_start_d = (state_d == StArm);
    cnt_stop_d  = (state_d == StStop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      rr_q        <= '0;
      idx_q       <= '0;
      tgt_q       <= '0;
      wd_q        <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      result_q    <= '0;
      cnt_rst_q   <= 1'b1;
      cnt_start_q <= 1'b0;
      cnt_stop_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      tgt_q       <= tgt_d;
      wd_q        <= wd_d;
      gnt_q       <= gnt_d;
      done_q      <= done_d;
      err_q       <= err_d;
      busy_q      <= busy_d;
      result_q    <= result_d;
      cnt_rst_q   <= cnt_rst_d;
      cnt_start_q <= cnt_start_d;
      cnt_stop_q  <= cnt_stop_d;
    end
  end

  assign gnt       = gnt_q;
  assign done      = done_q;
  assign err       = err_q;
  assign busy      = busy_q;
  assign result    = result_q;
  assign cnt_rst   = cnt_rst_q;
  assign cnt_start = cnt_start_q;
  assign cnt_stop  = cnt_stop_q;

endmodule

// File: tb/tb_count_sched.sv
// Bench for count_sched: behavioural counter, completion scoreboard, vector table and
// hand-written sequences for reset, round-robin, abort, timeout and mid-job reset.
module tb_count_sched;
  localparam int NREQ = 4;
  localparam int CW   = 4;
  localparam int TMO  = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req = '0;
  logic [15:0] target = '0;
  logic [3:0]  gnt, done, result;
  logic [3:0]  count = '0;
  logic        err, busy, cnt_rst, cnt_start, cnt_stop;
  logic        run = 1'b0;
  logic        stuck = 1'b0;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  typedef struct {
    logic [3:0] gnt;
    logic [3:0] done;
    logic       err;
    logic [3:0] result;
    int         at;
  } exp_t;

  typedef struct {
    logic [3:0]  r;
    logic [15:0] t;
    logic [3:0]  g;
    logic [3:0]  res;
    int          lat;
    int          starts;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t vecs[6];

  count_sched #(.NREQ(NREQ), .CW(CW), .TMO(TMO)) dut (
    .clk       (clk),
    .reset     (rst_n),
    .req       (req),
    .target    (target),
    .gnt       (gnt),
    .done      (done),
    .err       (err),
    .busy      (busy),
    .result    (result),
    .cnt_rst   (cnt_rst),
    .cnt_start (cnt_start),
    .cnt_stop  (cnt_stop),
    .count     (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Standard start/stop counter; 'stuck' freezes it to provoke the watchdog.
  always @(posedge clk) begin
    if (cnt_rst) begin
      count <= '0;
      run   <= 1'b0;
    end else if (cnt_stop) begin
      run <= 1'b0;
    end else if (cnt_start) begin
      run <= 1'b1;
    end else if (run && !stuck) begin
      count <= count + 1'b1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] g, input logic e, input logic [3:0] res, input int at);
    exp_t x;
    x.gnt    = g;
    x.done   = e ? 4'b0000 : g;
    x.err    = e;
    x.result = res;
    x.at     = at;
    sb.push_back(x);
  endtask

  task automatic wait_sb(input string name, input int budget, output int nstart);
    bit ok;
    ok     = 1'b0;
    nstart = 0;
    for (int k = 0; k < budget && !ok; k++) begin
      @(negedge clk);
      if (cnt_start) nstart++;
      if (sb.size() == 0) ok = 1'b1;
    end
    chk({name, "_finished"}, 32'(ok), 32'(1));
    if (!ok) sb.delete();
  endtask

  task automatic do_job(input logic [3:0] r, input logic [15:0] t, input logic [3:0] g,
                        input logic e, input logic [3:0] res, input int lat, input int starts,
                        input string name);
    int nstart;
    push(g, e, res, cyc + lat);
    req    = r;
    target = t;
    wait_sb(name, 60, nstart);
    chk({name, "_starts"}, 32'(nstart), 32'(starts));
    req = '0;
    repeat (3) @(negedge clk);
  endtask

  // Completion monitor plus per-cycle invariants.
  logic [3:0] prev_done = '0;
  logic       prev_err = 1'b0, prev_start = 1'b0, prev_stop = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("gnt_onehot0", 32'($onehot0(gnt)), 32'(1));
      chk("pulse_single_cycle", 32'((|(prev_done & done)) | (prev_err & err) |
                                    (prev_start & cnt_start) | (prev_stop & cnt_stop)), 32'(0));
      if ((|done) || err) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_completion: done=%b err=%b, required none", done, err);
        end else begin
          mon_e = sb.pop_front();
          chk("sb_gnt", 32'(gnt), 32'(mon_e.gnt));
          chk("sb_done", 32'(done), 32'(mon_e.done));
          chk("sb_err", 32'(err), 32'(mon_e.err));
          chk("sb_result", 32'(result), 32'(mon_e.result));
          chk("sb_cycle", 32'(cyc), 32'(mon_e.at));
        end
      end
    end
    prev_done  <= done;
    prev_err   <= err;
    prev_start <= cnt_start;
    prev_stop  <= cnt_stop;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int nstart, stops, dn, er;
    bit ok;

    vecs[0] = '{4'b0001, 16'h0000, 4'b0001, 4'h0, 2, 0};
    vecs[1] = '{4'b0100, 16'h0F00, 4'b0100, 4'hF, 19, 1};
    vecs[2] = '{4'b1001, 16'h7003, 4'b1000, 4'h7, 11, 1};
    vecs[3] = '{4'b1110, 16'h1111, 4'b0010, 4'h1, 5, 1};
    vecs[4] = '{4'b0011, 16'h0009, 4'b0001, 4'h9, 13, 1};
    vecs[5] = '{4'b1000, 16'h4000, 4'b1000, 4'h4, 8, 1};

    // Reset held with every requester asking.
    rst_n  = 1'b0;
    req    = 4'b1111;
    target = '0;
    repeat (3) @(negedge clk);
    chk("rst_gnt", 32'(gnt), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_cnt_rst", 32'(cnt_rst), 32'(1));
    chk("rst_done", 32'(done), 32'(0));
    chk("rst_err", 32'(err), 32'(0));
    chk("rst_result", 32'(result), 32'(0));
    chk("rst_start_stop", 32'({cnt_start, cnt_stop}), 32'(0));
    push(4'b0001, 1'b0, 4'h0, cyc + 2);
    rst_n = 1'b1;
    @(negedge clk);
    chk("first_grant", 32'(gnt), 32'(4'b0001));
    wait_sb("first_job", 20, nstart);
    req = '0;
    repeat (3) @(negedge clk);

    // Single job cycle-by-cycle (rr now 1).
    push(4'b0010, 1'b0, 4'h5, cyc + 9);
    req    = 4'b0010;
    target = 16'h0050;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) chk("single_gnt_c1", 32'(gnt), 32'(4'b0010));
      chk("single_cnt_start", 32'(cnt_start), 32'(k == 2));
      if (k == 10) chk("single_gnt_c10", 32'(gnt), 32'(0));
    end
    chk("single_sb_empty", 32'(sb.size()), 32'(0));
    req = '0;
    repeat (3) @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      do_job(vecs[i].r, vecs[i].t, vecs[i].g, 1'b0, vecs[i].res, vecs[i].lat,
             vecs[i].starts, $sformatf("vec%0d", i));
    end

    // Round-robin, back-to-back jobs with requests held.
    push(4'b0001, 1'b0, 4'h2, cyc + 6);
    push(4'b0010, 1'b0, 4'h2, cyc + 13);
    push(4'b1000, 1'b0, 4'h2, cyc + 20);
    push(4'b0001, 1'b0, 4'h2, cyc + 27);
    req    = 4'b1011;
    target = 16'h2222;
    wait_sb("round_robin", 50, nstart);
    chk("round_robin_starts", 32'(nstart), 32'(4));
    req = '0;
    repeat (3) @(negedge clk);

    // Abort: requester 2 withdraws after three RUN cycles.
    req    = 4'b0100;
    target = 16'h0900;
    repeat (6) @(negedge clk);
    chk("abort_busy_in_run", 32'(busy), 32'(1));
    req   = '0;
    stops = 0;
    dn    = 0;
    er    = 0;
    repeat (10) begin
      @(negedge clk);
      stops += int'(cnt_stop);
      dn    += int'(|done);
      er    += int'(err);
    end
    chk("abort_stops", 32'(stops), 32'(1));
    chk("abort_done", 32'(dn), 32'(0));
    chk("abort_err", 32'(er), 32'(0));
    chk("abort_result", 32'(result), 32'(4'h2));
    chk("abort_idle", 32'(busy), 32'(0));
    do_job(4'b1001, 16'h1001, 4'b1000, 1'b0, 4'h1, 5, 1, "after_abort");

    // Watchdog timeout with a frozen counter.
    stuck = 1'b1;
    do_job(4'b0001, 16'h0004, 4'b0001, 1'b1, 4'h1, 3 + TMO, 1, "timeout");
    stuck = 1'b0;

    // Target changed after grant must be ignored.
    push(4'b0010, 1'b0, 4'h3, cyc + 7);
    req    = 4'b0010;
    target = 16'h0030;
    repeat (2) @(negedge clk);
    target = 16'hFFFF;
    wait_sb("target_change", 30, nstart);
    req    = '0;
    target = '0;
    repeat (3) @(negedge clk);

    // Asynchronous reset in the middle of RUN.
    req    = 4'b0100;
    target = 16'h0800;
    ok     = 1'b0;
    for (int k = 0; k < 20 && !ok; k++) begin
      @(negedge clk);
      if (count == 4'd3) ok = 1'b1;
    end
    chk("midrst_reached_count3", 32'(ok), 32'(1));
    rst_n = 1'b0;
    #1;
    chk("midrst_gnt", 32'(gnt), 32'(0));
    chk("midrst_done_err", 32'({done, err}), 32'(0));
    chk("midrst_busy", 32'(busy), 32'(0));
    chk("midrst_result", 32'(result), 32'(0));
    chk("midrst_cnt_rst", 32'(cnt_rst), 32'(1));
    chk("midrst_start_stop", 32'({cnt_start, cnt_stop}), 32'(0));
    repeat (2) @(negedge clk);
    push(4'b0100, 1'b0, 4'h8, cyc + 12);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_gnt_c1", 32'(gnt), 32'(4'b0100));
    chk("postrst_clear_c1", 32'({cnt_rst, busy, cnt_start}), 32'(3'b110));
    @(negedge clk);
    chk("postrst_start_c2", 32'(cnt_start), 32'(1));
    wait_sb("postrst_job", 30, nstart);
    req = '0;
    repeat (3) @(negedge clk);
    chk("sb_drained", 32'(sb.size()), 32'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
